dma_engine: RTL

DMA_ENGINE -- requirements
Module: dma_engine

---
 rtl/dma_engine_pkg.sv | 9 +
 rtl/dma_engine_if.sv | 33 +++
 rtl/dma_engine.sv | 67 ++++++
 3 files changed

// File: rtl/dma_engine_pkg.sv
// dma_engine_pkg: shared state encoding, mode constants and default widths for the DMA engine.
package dma_engine_pkg;
    localparam int DMA_ADDR_W = 23;
    localparam int DMA_DATA_W = 32;
    localparam int DMA_LEN_W = 16;
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;
    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;
endpackage

// File: rtl/dma_engine_if.sv
// dma_engine_if: control, status and single-port RAM signals of the DMA engine.
interface dma_engine_if
    import dma_engine_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int LEN_W = DMA_LEN_W
);
    logic Start;
    logic Abort;
    logic Mode;
    logic [ADDR_W-1:0] SrcAddr;
    logic [ADDR_W-1:0] DstAddr;
    logic [LEN_W-1:0] Length;
    logic [DATA_W-1:0] FillData;
    logic [ADDR_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemWriteData;
    logic MemWE;
    logic MemRE;
    logic [DATA_W-1:0] MemReadData;
    logic Busy;
    logic Done;
    logic Aborted;
    logic [LEN_W-1:0] WordCount;
    modport slave (
        input Start, Abort, Mode, SrcAddr, DstAddr, Length, FillData, MemReadData,
        output MemAddress, MemWriteData, MemWE, MemRE, Busy, Done, Aborted, WordCount
    );
    modport master (
        output Start, Abort, Mode, SrcAddr, DstAddr, Length, FillData, MemReadData,
        input MemAddress, MemWriteData, MemWE, MemRE, Busy, Done, Aborted, WordCount
    );
endinterface

// File: rtl/dma_engine.sv
// dma_engine: copy/fill DMA over a single-port RAM; 2 cycles/word copy, 1 cycle/word fill.
module dma_engine
    import dma_engine_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int LEN_W = DMA_LEN_W
) (
    input logic Clk,
    input logic Reset,
    dma_engine_if.slave bus
);
    state_t state, nxt;
    logic accept, mode, mode_n;
    logic [ADDR_W-1:0] src, dst, src_n, dst_n;
    logic [LEN_W-1:0] len, wc_n;
    logic [DATA_W-1:0] fill, fill_n, data_q, data_n;
    // All memory/status outputs are registered from the next-state view, so they line up with the state they describe.
    always_comb begin
        accept = state == IDLE && bus.Start;
        src_n = accept ? bus.SrcAddr : src;
        dst_n = accept ? bus.DstAddr : dst;
        mode_n = accept ? bus.Mode : mode;
        fill_n = accept ? bus.FillData : fill;
        data_n = state == READ ? bus.MemReadData : data_q;
        wc_n = accept ? '0 : state == WRITE ? bus.WordCount + 1'b1 : bus.WordCount;
        nxt = accept ? (bus.Length == '0 ? FIN : bus.Mode == MODE_FILL ? WRITE : READ)
            : state == READ ? (bus.Abort ? FIN : WRITE)
            : state == WRITE ? (bus.Abort || wc_n == len ? FIN : mode == MODE_FILL ? WRITE : READ)
            : IDLE;
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            src <= '0;
            dst <= '0;
            len <= '0;
            mode <= MODE_COPY;
            fill <= '0;
            data_q <= '0;
            bus.WordCount <= '0;
            bus.Aborted <= 1'b0;
            bus.Busy <= 1'b0;
            bus.Done <= 1'b0;
            bus.MemRE <= 1'b0;
            bus.MemWE <= 1'b0;
            bus.MemAddress <= '0;
            bus.MemWriteData <= '0;
        end else begin
            state <= nxt;
            src <= src_n;
            dst <= dst_n;
            len <= accept ? bus.Length : len;
            mode <= mode_n;
            fill <= fill_n;
            data_q <= data_n;
            bus.WordCount <= wc_n;
            bus.Aborted <= accept ? 1'b0 : (state == READ || state == WRITE) && bus.Abort ? 1'b1 : bus.Aborted;
            bus.Busy <= nxt != IDLE;
            bus.Done <= nxt == FIN;
            bus.MemRE <= nxt == READ;
            bus.MemWE <= nxt == WRITE;
            bus.MemAddress <= nxt == READ ? src_n + ADDR_W'(wc_n) : nxt == WRITE ? dst_n + ADDR_W'(wc_n) : '0;
            bus.MemWriteData <= nxt == WRITE ? (mode_n == MODE_FILL ? fill_n : data_n) : '0;
        end
    end
endmodule
